// File: rtl/io_input_conditioner.sv
// io_input_conditioner: sync+debounce keys/switches into pin-polarity levels (button_export/switch_export), press/release/change pulses and a clearable 8-bit press counter
module io_input_conditioner #(
  parameter int N_BUTTONS = 4,
  parameter int N_SWITCHES = 10,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BUTTON_ACTIVE_LOW = 1
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [N_BUTTONS-1:0]  key_raw,
  input  logic [N_SWITCHES-1:0] sw_raw,
  output logic [N_BUTTONS-1:0]  button_export,
  output logic [N_SWITCHES-1:0] switch_export,
  output logic [N_BUTTONS-1:0]  button_press,
  output logic [N_BUTTONS-1:0]  button_release,
  output logic [N_SWITCHES-1:0] switch_change,
  input  logic                  press_count_clr,
  output logic [7:0]            press_count
);
  localparam int N = N_BUTTONS + N_SWITCHES;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [N_BUTTONS-1:0] KEY_REL = (BUTTON_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [N-1:0] RST_LVL = {{N_SWITCHES{1'b0}}, KEY_REL};
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0] sync, stable, flip;
  logic [N-1:0][CW-1:0] cnt, cnt_nxt;
  logic [N_BUTTONS-1:0] press_c, release_c;
  logic [7:0] press_inc;
  assign sync = sync_q[SYNC_STAGES-1];
  for (genvar b = 0; b < N; b++) begin : g_bit
    assign flip[b] = (sync[b] != stable[b]) && (cnt[b] == CNT_MAX);
    assign cnt_nxt[b] = (sync[b] != stable[b] && !flip[b]) ? cnt[b] + CW'(1) : '0;
  end
  assign press_c = flip[N_BUTTONS-1:0] & (sync[N_BUTTONS-1:0] ^ KEY_REL);
  assign release_c = flip[N_BUTTONS-1:0] & ~(sync[N_BUTTONS-1:0] ^ KEY_REL);
  always_comb begin
    press_inc = '0;
    for (int i = 0; i < N_BUTTONS; i++) press_inc = press_inc + 8'(press_c[i]);
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_q <= {SYNC_STAGES{RST_LVL}};
      stable <= RST_LVL;
      cnt <= '0;
      button_press <= '0;
      button_release <= '0;
      switch_change <= '0;
      press_count <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {sw_raw, key_raw}};
      stable <= stable ^ flip;
      cnt <= cnt_nxt;
      button_press <= press_c;
      button_release <= release_c;
      switch_change <= flip[N-1:N_BUTTONS];
      press_count <= (press_count_clr ? 8'd0 : press_count) + press_inc;
    end
  end
  assign button_export = stable[N_BUTTONS-1:0];
  assign switch_export = stable[N-1:N_BUTTONS];
endmodule

// File: tb/tb_io_input_conditioner.sv
// tb_io_input_conditioner: scoreboard bench for io_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2
module tb_io_input_conditioner;
  logic clk_clk = 1'b0;
  logic reset_reset_n = 1'b0;
  logic [3:0] key_raw = 4'hF;
  logic [9:0] sw_raw = '0;
  logic press_count_clr = 1'b0;
  logic [3:0] button_export, button_press, button_release;
  logic [9:0] switch_export, switch_change;
  logic [7:0] press_count;
  io_input_conditioner #(
    .N_BUTTONS(4), .N_SWITCHES(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .BUTTON_ACTIVE_LOW(1)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .key_raw(key_raw), .sw_raw(sw_raw),
    .button_export(button_export), .switch_export(switch_export), .button_press(button_press),
    .button_release(button_release), .switch_change(switch_change),
    .press_count_clr(press_count_clr), .press_count(press_count)
  );
  always #5 clk_clk = ~clk_clk;
  typedef struct {
    int at;
    logic [3:0] bp, br;
    logic [9:0] sc;
    logic [3:0] be;
    logic [9:0] se;
    logic [7:0] pc;
  } ev_t;
  ev_t q[$];
  int edge_n = 0;
  int checks = 0;
  int passed = 0;
  logic [7:0] pc_m = '0;
  logic [9:0] se_m = '0;
  always @(posedge clk_clk) edge_n <= edge_n + 1;
  always @(negedge clk_clk) begin : monitor
    ev_t e;
    if (reset_reset_n && (|{button_press, button_release, switch_change})) begin
      checks++;
      if (q.size() == 0)
        $display("FAIL unexpected_event edge %0d: press %h release %h change %h, expected no event",
                 edge_n, button_press, button_release, switch_change);
      else begin
        e = q.pop_front();
        if (edge_n == e.at && {button_press, button_release, switch_change, button_export, switch_export, press_count}
            === {e.bp, e.br, e.sc, e.be, e.se, e.pc})
          passed++;
        else
          $display("FAIL event: got edge %0d press %h release %h change %h btn %h sw %h cnt %0d; expected edge %0d press %h release %h change %h btn %h sw %h cnt %0d",
                   edge_n, button_press, button_release, switch_change, button_export, switch_export, press_count,
                   e.at, e.bp, e.br, e.sc, e.be, e.se, e.pc);
      end
    end
  end
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  task automatic nclk(input int n);
    repeat (n) @(negedge clk_clk);
  endtask
  task automatic push(input int dly, input logic [3:0] bp, input logic [3:0] br, input logic [9:0] sc,
                      input logic [3:0] be, input logic [9:0] se, input logic [7:0] pc);
    ev_t e;
    e.at = edge_n + dly;
    e.bp = bp;
    e.br = br;
    e.sc = sc;
    e.be = be;
    e.se = se;
    e.pc = pc;
    q.push_back(e);
  endtask
  task automatic drain(input string name);
    int k = 0;
    while (q.size() != 0 && k < 40) begin
      @(negedge clk_clk);
      k++;
    end
    check({name, "_drain"}, 64'(q.size()), 64'd0);
  endtask
  task automatic press_release(input int b);
    key_raw = ~(4'b1 << b);
    pc_m = pc_m + 8'd1;
    push(6, 4'b1 << b, 4'h0, 10'h0, key_raw, se_m, pc_m);
    drain("press");
    key_raw = 4'hF;
    push(6, 4'h0, 4'b1 << b, 10'h0, 4'hF, se_m, pc_m);
    drain("release");
  endtask
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    nclk(3);
    reset_reset_n = 1'b1;
    repeat (20) begin
      nclk(1);
      check("idle_after_reset", {button_press, button_release, switch_change, button_export, switch_export, press_count},
            {4'h0, 4'h0, 10'h0, 4'hF, 10'h0, 8'h0});
    end
    key_raw = 4'hE;
    pc_m = 8'd1;
    push(6, 4'h1, 4'h0, 10'h0, 4'hE, 10'h0, 8'd1);
    nclk(5);
    check("t2_not_before_edge6", 64'(button_export), 64'hF);
    nclk(5);
    key_raw = 4'hF;
    push(6, 4'h0, 4'h1, 10'h0, 4'hF, 10'h0, 8'd1);
    drain("t2");
    check("t2_count", 64'(press_count), 64'd1);
    sw_raw = 10'h008;
    nclk(3);
    sw_raw = 10'h000;
    nclk(1);
    sw_raw = 10'h008;
    se_m = 10'h008;
    push(6, 4'h0, 4'h0, 10'h008, 4'hF, 10'h008, 8'd1);
    nclk(5);
    check("t3_not_early", 64'(switch_export), 64'h0);
    drain("t3");
    sw_raw = 10'h028;
    nclk(3);
    sw_raw = 10'h008;
    nclk(12);
    check("t3_glitch_ignored", 64'(switch_export), 64'h008);
    while (pc_m != 8'd254) press_release(0);
    check("t4_pre", 64'(press_count), 64'd254);
    key_raw = 4'h9;
    pc_m = 8'd0;
    push(6, 4'h6, 4'h0, 10'h0, 4'h9, 10'h008, 8'd0);
    drain("t4");
    check("t4_wrap", 64'(press_count), 64'd0);
    key_raw = 4'hF;
    push(6, 4'h0, 4'h6, 10'h0, 4'hF, 10'h008, 8'd0);
    drain("t4r");
    while (pc_m != 8'd17) press_release(0);
    key_raw = 4'h7;
    push(6, 4'h8, 4'h0, 10'h0, 4'h7, 10'h008, 8'd1);
    nclk(5);
    check("t5_pre", 64'(press_count), 64'd17);
    press_count_clr = 1'b1;
    nclk(1);
    press_count_clr = 1'b0;
    pc_m = 8'd1;
    drain("t5");
    check("t5_clr_with_press", 64'(press_count), 64'd1);
    key_raw = 4'hF;
    push(6, 4'h0, 4'h8, 10'h0, 4'hF, 10'h008, 8'd1);
    drain("t5r");
    press_count_clr = 1'b1;
    nclk(1);
    press_count_clr = 1'b0;
    pc_m = 8'd0;
    check("clr_idle", 64'(press_count), 64'd0);
    sw_raw = 10'h000;
    se_m = 10'h000;
    push(6, 4'h0, 4'h0, 10'h008, 4'hF, 10'h000, 8'd0);
    drain("sw_fall");
    key_raw = 4'hE;
    nclk(4);
    #2;
    reset_reset_n = 1'b0;
    #1;
    check("t6_in_reset", {button_press, button_export, press_count}, {4'h0, 4'hF, 8'h0});
    nclk(3);
    reset_reset_n = 1'b1;
    pc_m = 8'd1;
    push(6, 4'h1, 4'h0, 10'h0, 4'hE, 10'h000, 8'd1);
    nclk(5);
    check("t6_fresh_latency", 64'(button_export), 64'hF);
    drain("t6");
    key_raw = 4'hF;
    push(6, 4'h0, 4'h1, 10'h0, 4'hF, 10'h000, 8'd1);
    drain("t6r");
    nclk(10);
    check("final_count", 64'(press_count), 64'd1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
